// File: rtl/debug_pkg.sv
// Shared types and helpers for the 7-segment debug view controller.
// The view enum order matches the display mux input order.
package debug_pkg;

    localparam int NUM_VIEWS = 8;

    typedef enum logic [2:0] {
        VIEW_INSTR   = 3'd0,
        VIEW_RD1     = 3'd1,
        VIEW_RD2     = 3'd2,
        VIEW_RESULT  = 3'd3,
        VIEW_IMMEXT  = 3'd4,
        VIEW_ALUSRC  = 3'd5,
        VIEW_PC      = 3'd6,
        VIEW_CONTROL = 3'd7
    } view_e;

    // Wraps VIEW_CONTROL back to VIEW_INSTR through 3-bit overflow.
    function automatic view_e next_view(input view_e v);
        return view_e'(v + 3'd1);
    endfunction

    function automatic logic [NUM_VIEWS-1:0] view_onehot(input view_e v);
        return NUM_VIEWS'(1) << v;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Active-low push-button front end: 2-FF synchroniser, stability counter,
// and a one-cycle registered pulse on each accepted press.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_n,
    output logic press_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    logic          sync1_q, sync2_q;
    logic          stable_q, stable_d;
    logic          stable_dly_q;
    logic          pulse_q;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path infers a latch.
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            stable_q     <= 1'b1;
            stable_dly_q <= 1'b1;
            cnt_q        <= '0;
            pulse_q      <= 1'b0;
        end else begin
            sync1_q      <= raw_n;
            sync2_q      <= sync1_q;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            cnt_q        <= cnt_d;
            pulse_q      <= stable_dly_q & ~stable_q;
        end
    end

    assign press_pulse = pulse_q;

endmodule

// File: rtl/debug_view_ctrl.sv
// Board front end for the debug display: selects the viewed pipeline signal
// (manual or timed advance) and gates the processor clock for single-step / run.
module debug_view_ctrl
    import debug_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int AUTO_PERIOD     = 50_000_000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 key_step_n,
    input  logic                 key_sel_n,
    input  logic                 sw_run,
    input  logic                 sw_auto,
    output logic [2:0]           selm,
    output logic                 cpu_step,
    output logic [NUM_VIEWS-1:0] led_view
);

    localparam int AW = $clog2(AUTO_PERIOD);

    logic step_pulse, sel_pulse;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_key (
        .clk        (clk),
        .rst        (rst),
        .raw_n      (key_step_n),
        .press_pulse(step_pulse)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sel_key (
        .clk        (clk),
        .rst        (rst),
        .raw_n      (key_sel_n),
        .press_pulse(sel_pulse)
    );

    // Switches are level-sensitive; a synchroniser is enough without debounce.
    logic [1:0] run_sync_q, auto_sync_q;
    logic       run_s, auto_s;

    assign run_s  = run_sync_q[1];
    assign auto_s = auto_sync_q[1];

    view_e                selm_q, selm_d;
    logic [NUM_VIEWS-1:0] led_q;
    logic [AW-1:0]        auto_cnt_q, auto_cnt_d;
    logic                 cpu_step_q, cpu_step_d;
    logic                 auto_tc;

    always_comb begin
        auto_tc    = auto_s && (auto_cnt_q == AW'(AUTO_PERIOD - 1));
        selm_d     = selm_q;
        auto_cnt_d = '0;
        // A manual press and a timed advance in the same cycle merge into one step.
        if (sel_pulse || auto_tc) begin
            selm_d = next_view(selm_q);
        end else if (auto_s) begin
            auto_cnt_d = auto_cnt_q + AW'(1);
        end
        cpu_step_d = run_s ? 1'b1 : step_pulse;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_sync_q  <= '0;
            auto_sync_q <= '0;
            selm_q      <= VIEW_INSTR;
            led_q       <= view_onehot(VIEW_INSTR);
            auto_cnt_q  <= '0;
            cpu_step_q  <= 1'b0;
        end else begin
            run_sync_q  <= {run_sync_q[0], sw_run};
            auto_sync_q <= {auto_sync_q[0], sw_auto};
            selm_q      <= selm_d;
            led_q       <= view_onehot(selm_d);
            auto_cnt_q  <= auto_cnt_d;
            cpu_step_q  <= cpu_step_d;
        end
    end

    assign selm     = selm_q;
    assign led_view = led_q;
    assign cpu_step = cpu_step_q;

endmodule

// File: tb/tb_debug_view_ctrl.sv
// Directed bench for debug_view_ctrl with DEBOUNCE_CYCLES=4, AUTO_PERIOD=16.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_debug_view_ctrl;

    localparam int DEB  = 4;
    localparam int AUTO = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_step_n, key_sel_n, sw_run, sw_auto;
    logic [2:0] selm;
    logic       cpu_step;
    logic [7:0] led_view;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    debug_view_ctrl #(.DEBOUNCE_CYCLES(DEB), .AUTO_PERIOD(AUTO)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_step_n(key_step_n),
        .key_sel_n (key_sel_n),
        .sw_run    (sw_run),
        .sw_auto   (sw_auto),
        .selm      (selm),
        .cpu_step  (cpu_step),
        .led_view  (led_view)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    // Full press: low long enough to qualify, then release long enough to settle.
    task automatic press_sel();
        key_sel_n = 1'b0;
        tick(10);
        key_sel_n = 1'b1;
        tick(10);
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        key_step_n = 1'b1;
        key_sel_n  = 1'b1;
        sw_run     = 1'b0;
        sw_auto    = 1'b0;
        tick(2);
        total_cnt++;
        if ({selm, led_view, cpu_step} !== {3'd0, 8'h01, 1'b0})
            $display("FAIL reset_state: got selm=%0d led=%h step=%b, want 0 01 0", selm, led_view, cpu_step);
        else pass_cnt++;
        rst = 1'b0;
        tick(3);
        total_cnt++;
        if ({selm, led_view, cpu_step} !== {3'd0, 8'h01, 1'b0})
            $display("FAIL idle_after_reset: got selm=%0d led=%h step=%b, want 0 01 0", selm, led_view, cpu_step);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        sw_run = 1'b1;
        press_sel();
        total_cnt++;
        if ({selm, cpu_step} !== {3'd1, 1'b1})
            $display("FAIL pre_async_reset: got selm=%0d step=%b, want 1 1", selm, cpu_step);
        else pass_cnt++;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total_cnt++;
        if ({selm, led_view, cpu_step} !== {3'd0, 8'h01, 1'b0})
            $display("FAIL async_reset: got selm=%0d led=%h step=%b, want 0 01 0", selm, led_view, cpu_step);
        else pass_cnt++;
        sw_run = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(4);
    endtask

    task automatic test_glitch_and_hold();
        do_reset();
        key_sel_n = 1'b0;
        tick(3);
        key_sel_n = 1'b1;
        tick(12);
        total_cnt++;
        if (selm !== 3'd0) $display("FAIL short_glitch: got selm=%0d, want 0", selm);
        else pass_cnt++;
        // 2 sync + 4 count edges drop stable, pulse on edge 7, selm on edge 8.
        key_sel_n = 1'b0;
        tick(7);
        total_cnt++;
        if (selm !== 3'd0) $display("FAIL hold_early: got selm=%0d, want 0", selm);
        else pass_cnt++;
        tick(1);
        total_cnt++;
        if ({selm, led_view} !== {3'd1, 8'h02})
            $display("FAIL hold_event: got selm=%0d led=%h, want 1 02", selm, led_view);
        else pass_cnt++;
        tick(12);
        key_sel_n = 1'b1;
        tick(12);
        total_cnt++;
        if (selm !== 3'd1) $display("FAIL hold_no_repeat: got selm=%0d, want 1", selm);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        logic [2:0] exp_sel;
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            press_sel();
            exp_sel = 3'(i % 8);
            total_cnt++;
            if ({selm, led_view} !== {exp_sel, 8'h01 << exp_sel})
                $display("FAIL wrap_%0d: got selm=%0d led=%h, want %0d %h", i, selm, led_view, exp_sel, 8'h01 << exp_sel);
            else pass_cnt++;
        end
    endtask

    task automatic test_step();
        do_reset();
        sw_run     = 1'b0;
        key_step_n = 1'b0;
        tick(7);
        total_cnt++;
        if (cpu_step !== 1'b0) $display("FAIL step_early: got %b, want 0", cpu_step);
        else pass_cnt++;
        tick(1);
        total_cnt++;
        if (cpu_step !== 1'b1) $display("FAIL step_pulse: got %b, want 1", cpu_step);
        else pass_cnt++;
        tick(1);
        total_cnt++;
        if (cpu_step !== 1'b0) $display("FAIL step_one_cycle: got %b, want 0", cpu_step);
        else pass_cnt++;
        tick(8);
        total_cnt++;
        if (cpu_step !== 1'b0) $display("FAIL step_held: got %b, want 0", cpu_step);
        else pass_cnt++;
        key_step_n = 1'b1;
        tick(10);
        sw_run = 1'b1;
        tick(3);
        key_step_n = 1'b0;
        for (int i = 0; i < 12; i++) begin
            total_cnt++;
            if (cpu_step !== 1'b1) $display("FAIL run_mode_%0d: got %b, want 1", i, cpu_step);
            else pass_cnt++;
            tick(1);
        end
        key_step_n = 1'b1;
        tick(10);
        sw_run = 1'b0;
        tick(2);
        total_cnt++;
        if (cpu_step !== 1'b1) $display("FAIL run_exit_sync: got %b, want 1", cpu_step);
        else pass_cnt++;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            total_cnt++;
            if (cpu_step !== 1'b0) $display("FAIL run_to_step_%0d: got %b, want 0", i, cpu_step);
            else pass_cnt++;
        end
    endtask

    task automatic test_auto();
        do_reset();
        sw_auto = 1'b1;
        // Sync takes 2 edges; count 0..15 then advance on edge 18.
        tick(17);
        total_cnt++;
        if (selm !== 3'd0) $display("FAIL auto_before_first: got selm=%0d, want 0", selm);
        else pass_cnt++;
        tick(1);
        total_cnt++;
        if ({selm, led_view} !== {3'd1, 8'h02})
            $display("FAIL auto_first: got selm=%0d led=%h, want 1 02", selm, led_view);
        else pass_cnt++;
        tick(15);
        total_cnt++;
        if (selm !== 3'd1) $display("FAIL auto_before_second: got selm=%0d, want 1", selm);
        else pass_cnt++;
        tick(1);
        total_cnt++;
        if (selm !== 3'd2) $display("FAIL auto_second: got selm=%0d, want 2", selm);
        else pass_cnt++;
        // Next terminal count is 16 edges away; launch a press whose pulse lands on it.
        tick(8);
        key_sel_n = 1'b0;
        tick(7);
        total_cnt++;
        if (selm !== 3'd2) $display("FAIL coincide_before: got selm=%0d, want 2", selm);
        else pass_cnt++;
        tick(1);
        total_cnt++;
        if (selm !== 3'd3) $display("FAIL coincide_single: got selm=%0d, want 3", selm);
        else pass_cnt++;
        tick(15);
        total_cnt++;
        if (selm !== 3'd3) $display("FAIL coincide_restart: got selm=%0d, want 3", selm);
        else pass_cnt++;
        tick(1);
        total_cnt++;
        if (selm !== 3'd4) $display("FAIL auto_after_coincide: got selm=%0d, want 4", selm);
        else pass_cnt++;
        key_sel_n = 1'b1;
        sw_auto   = 1'b0;
        tick(2);
        tick(40);
        total_cnt++;
        if (selm !== 3'd4) $display("FAIL auto_off: got selm=%0d, want 4", selm);
        else pass_cnt++;
    endtask

    task automatic test_bounce();
        do_reset();
        key_sel_n = 1'b0; tick(2);
        key_sel_n = 1'b1; tick(1);
        key_sel_n = 1'b0; tick(2);
        key_sel_n = 1'b1; tick(1);
        key_sel_n = 1'b0;
        tick(7);
        total_cnt++;
        if (selm !== 3'd0) $display("FAIL bounce_early: got selm=%0d, want 0", selm);
        else pass_cnt++;
        tick(1);
        total_cnt++;
        if (selm !== 3'd1) $display("FAIL bounce_event: got selm=%0d, want 1", selm);
        else pass_cnt++;
        tick(2);
        key_sel_n = 1'b1;
        tick(12);
        total_cnt++;
        if (selm !== 3'd1) $display("FAIL bounce_single: got selm=%0d, want 1", selm);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_press();
        do_reset();
        key_sel_n = 1'b0;
        tick(4);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(7);
        total_cnt++;
        if (selm !== 3'd0) $display("FAIL requalify_early: got selm=%0d, want 0", selm);
        else pass_cnt++;
        tick(1);
        total_cnt++;
        if (selm !== 3'd1) $display("FAIL requalify_event: got selm=%0d, want 1", selm);
        else pass_cnt++;
        tick(10);
        key_sel_n = 1'b1;
        tick(10);
        total_cnt++;
        if (selm !== 3'd1) $display("FAIL requalify_single: got selm=%0d, want 1", selm);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_async_reset();
        test_glitch_and_hold();
        test_wrap();
        test_step();
        test_auto();
        test_bounce();
        test_reset_mid_press();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
